// File: rtl/log_pkg.sv
// Shared types and constants for the event-log drain.
// Entry layout: {par, hrdy, nrdy, nack, host_data[31:0], ndt[39:0]}.
package log_pkg;

  localparam int LOG_ENTRY_W = 76;

  localparam int PAR  = 75;
  localparam int HRDY = 74;
  localparam int NRDY = 73;
  localparam int NACK = 72;

  localparam logic [15:0] TRAILER_MAGIC = 16'hE0F0;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_EVAL,
    S_W0,
    S_W1,
    S_W2,
    S_TRL,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    SEL_W0,
    SEL_W1,
    SEL_W2,
    SEL_TRL
  } sel_t;

endpackage

// File: rtl/log_drain_if.sv
// Output word stream of the log drain.
// Master drives valid/data/last, slave drives ready.
interface log_drain_if;

  logic        valid;
  logic        ready;
  logic [31:0] data;
  logic        last;

  modport master (
    output valid,
    output data,
    output last,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  last,
    output ready
  );

endinterface

// File: rtl/log_word_pack.sv
// Packs one log entry into its three stream words,
// or builds the trailer from the kept-entry count.
module log_word_pack
  import log_pkg::*;
(
  input  logic [LOG_ENTRY_W-1:0] entry,
  input  logic [15:0]            idx,
  input  logic [15:0]            kept,
  input  sel_t                   sel,
  output logic [31:0]            word
);

  logic [3:0] flags;

  assign flags = {entry[PAR], entry[HRDY],
                  entry[NRDY], entry[NACK]};

  // Word select: W0 header, W1 host data, W2 ndt low, trailer.
  always_comb begin
    word = '0;
    unique case (sel)
      SEL_W0:  word = {flags, 4'h0, entry[39:32], idx};
      SEL_W1:  word = entry[71:40];
      SEL_W2:  word = entry[31:0];
      SEL_TRL: word = {TRAILER_MAGIC, kept};
      default: word = '0;
    endcase
  end

endmodule

// File: rtl/log_drain.sv
// Scans the event log, optionally filtering empty-flag
// entries, and streams each entry as three words + trailer.
module log_drain
  import log_pkg::*;
#(
  parameter  int DATA_SIZE = 32,
  parameter  int TAG_SIZE  = 8,
  parameter  int MEM_DEPTH = 256,
  localparam int ADDR_W    = $clog2(MEM_DEPTH),
  localparam int ENTRY_W   = 4 + 2 * DATA_SIZE + TAG_SIZE
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               filter_en,
  input  logic [ADDR_W:0]    log_count,
  output logic [ADDR_W-1:0]  rd_addr,
  output logic               rd_en,
  input  logic [ENTRY_W-1:0] rd_data,
  log_drain_if.master        out,
  output logic               busy,
  output logic               done,
  output logic [15:0]        parity_cnt
);

  localparam logic [ADDR_W:0] DEPTH =
    (ADDR_W + 1)'(MEM_DEPTH);

  state_t state;
  state_t state_n;

  logic [ADDR_W:0]        idx;
  logic [ADDR_W:0]        idx_nx;
  logic [ADDR_W:0]        cnt;
  logic [ADDR_W:0]        cnt_in;
  logic                   filt;
  logic [LOG_ENTRY_W-1:0] entry;
  logic [15:0]            kept;
  logic [3:0]             flags;
  logic                   skip;
  logic                   last_ent;
  logic                   hs;
  logic                   kill;
  logic                   adv;
  logic                   go;
  sel_t                   sel;
  logic [31:0]            word;

  assign cnt_in   = (log_count > DEPTH) ? DEPTH : log_count;
  assign idx_nx   = idx + 1'b1;
  assign last_ent = (idx_nx >= cnt);
  assign flags    = {entry[PAR], entry[HRDY],
                     entry[NRDY], entry[NACK]};
  assign skip     = filt && (flags == 4'h0);
  assign hs       = out.valid && out.ready;
  assign go       = (state == S_IDLE) && start;
  assign kill     = abort && (state != S_IDLE);
  assign adv      = ((state == S_EVAL) && skip) ||
                    ((state == S_W2) && hs);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // Next state and decoded outputs; abort overrides all.
  always_comb begin
    state_n   = state;
    rd_en     = 1'b0;
    out.valid = 1'b0;
    out.last  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    sel       = SEL_W0;
    unique case (state)
      S_IDLE: begin
        if (start)
          state_n = (cnt_in == '0) ? S_TRL : S_RD;
      end
      S_RD: begin
        busy    = 1'b1;
        rd_en   = 1'b1;
        state_n = S_WAIT;
      end
      S_WAIT: begin
        busy    = 1'b1;
        state_n = S_EVAL;
      end
      S_EVAL: begin
        busy = 1'b1;
        if (!skip)         state_n = S_W0;
        else if (last_ent) state_n = S_TRL;
        else               state_n = S_RD;
      end
      S_W0: begin
        busy      = 1'b1;
        out.valid = 1'b1;
        sel       = SEL_W0;
        if (hs) state_n = S_W1;
      end
      S_W1: begin
        busy      = 1'b1;
        out.valid = 1'b1;
        sel       = SEL_W1;
        if (hs) state_n = S_W2;
      end
      S_W2: begin
        busy      = 1'b1;
        out.valid = 1'b1;
        sel       = SEL_W2;
        if (hs) state_n = last_ent ? S_TRL : S_RD;
      end
      S_TRL: begin
        busy      = 1'b1;
        out.valid = 1'b1;
        out.last  = 1'b1;
        sel       = SEL_TRL;
        if (hs) state_n = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    if (kill) state_n = S_IDLE;
  end

  // Scan bookkeeping: config latch, index, entry, counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt       <= 1'b0;
      cnt        <= '0;
      idx        <= '0;
      entry      <= '0;
      kept       <= '0;
      parity_cnt <= '0;
    end else if (go) begin
      filt       <= filter_en;
      cnt        <= cnt_in;
      idx        <= '0;
      kept       <= '0;
      parity_cnt <= '0;
    end else if (!kill) begin
      if (state == S_WAIT)
        entry <= rd_data;
      if ((state == S_EVAL) && !skip) begin
        if (kept != 16'hFFFF)
          kept <= kept + 16'd1;
        if (entry[PAR] && (parity_cnt != 16'hFFFF))
          parity_cnt <= parity_cnt + 16'd1;
      end
      if (adv && !last_ent)
        idx <= idx_nx;
    end
  end

  log_word_pack u_pack (
    .entry (entry),
    .idx   (16'(idx)),
    .kept  (kept),
    .sel   (sel),
    .word  (word)
  );

  assign rd_addr  = idx[ADDR_W-1:0];
  assign out.data = out.valid ? word : 32'h0;

endmodule

// File: tb/tb_log_drain.sv
// Self-checking bench for log_drain: scan table plus
// abort and async-reset sequences, scoreboard on words.
module tb_log_drain;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic        filter_en;
  logic [8:0]  log_count;
  logic [7:0]  rd_addr;
  logic        rd_en;
  logic [75:0] rd_data;
  logic        busy;
  logic        done;
  logic [15:0] parity_cnt;

  log_drain_if out ();

  log_drain #(
    .DATA_SIZE (32),
    .TAG_SIZE  (8),
    .MEM_DEPTH (256)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .filter_en  (filter_en),
    .log_count  (log_count),
    .rd_addr    (rd_addr),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .out        (out),
    .busy       (busy),
    .done       (done),
    .parity_cnt (parity_cnt)
  );

  always #5 clk = ~clk;

  logic [75:0] mem [256];

  always @(posedge clk)
    if (rd_en) rd_data <= mem[rd_addr];

  logic rnd_ready = 1'b0;
  logic rnd_bit   = 1'b1;
  logic ready_fix = 1'b1;

  assign out.ready = rnd_ready ? rnd_bit : ready_fix;

  always @(posedge clk) begin
    #1;
    rnd_bit = 1'($urandom_range(0, 1));
  end

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(string name,
                       logic [63:0] act,
                       logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h",
               name, act, exp);
    end
  endtask

  logic [32:0] sb_q [$];
  int          xfers     = 0;
  int          done_cnt  = 0;
  int          rden_cnt  = 0;
  logic [7:0]  last_addr = '0;
  logic [31:0] trl_word  = '0;
  bit          stall_chk = 0;
  bit          prev_stl  = 0;
  logic [31:0] prev_data = '0;
  logic        prev_last = 1'b0;

  // Monitor: scoreboard pops, stall stability, event counts.
  always @(negedge clk) begin
    if (reset) begin
      prev_stl = 0;
    end else begin
      if (done) done_cnt++;
      if (rd_en) begin
        rden_cnt++;
        last_addr = rd_addr;
      end
      if (stall_chk && prev_stl)
        check("stall_hold",
              {out.valid, out.last, out.data},
              {1'b1, prev_last, prev_data});
      if (out.valid && out.ready) begin
        xfers++;
        if (out.last) trl_word = out.data;
        if (sb_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL sb_extra: got %h want none",
                   out.data);
        end else begin
          check("word", {out.last, out.data},
                sb_q.pop_front());
        end
      end
      prev_stl  = out.valid && !out.ready;
      prev_data = out.data;
      prev_last = out.last;
    end
  end

  // Reference model of the stream for one scan.
  task automatic push_expected(int n, bit f);
    int          m;
    int          k;
    logic [75:0] e;
    logic [3:0]  fl;
    m = (n > 256) ? 256 : n;
    k = 0;
    for (int i = 0; i < m; i++) begin
      e  = mem[i];
      fl = e[75:72];
      if (f && fl == 4'h0) continue;
      sb_q.push_back({1'b0, fl, 4'h0, e[39:32],
                      16'(i)});
      sb_q.push_back({1'b0, e[71:40]});
      sb_q.push_back({1'b0, e[31:0]});
      k++;
    end
    sb_q.push_back({1'b1, 16'hE0F0, 16'(k)});
  endtask

  task automatic pulse_start(int n, bit f);
    @(posedge clk);
    #1;
    start     = 1'b1;
    filter_en = f;
    log_count = 9'(n);
    @(posedge clk);
    #1;
    start     = 1'b0;
    filter_en = 1'b0;
    log_count = '0;
  endtask

  task automatic wait_word(logic [31:0] w,
                           output bit ok);
    ok = 0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk);
      #1;
      if (out.valid && out.data == w) begin
        ok = 1;
        break;
      end
    end
  endtask

  typedef struct {
    int          cnt;
    bit          filt;
    bit          rnd;
    int          words;
    logic [31:0] trailer;
    int          par;
    int          rdens;
    logic [7:0]  laddr;
  } vec_t;

  vec_t tbl [6];

  task automatic apply_vec(vec_t v, string tag);
    int cyc;
    sb_q.delete();
    push_expected(v.cnt, v.filt);
    xfers     = 0;
    done_cnt  = 0;
    rden_cnt  = 0;
    rnd_ready = v.rnd;
    stall_chk = v.rnd;
    pulse_start(v.cnt, v.filt);
    check({tag, "_busy_rise"}, 64'(busy), 64'd1);
    cyc = 0;
    while (done_cnt == 0 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    if (done_cnt == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: got no done want done",
               tag);
    end
    repeat (3) @(negedge clk);
    rnd_ready = 1'b0;
    stall_chk = 0;
    check({tag, "_words"}, 64'(xfers), 64'(v.words));
    check({tag, "_trailer"}, 64'(trl_word),
          64'(v.trailer));
    check({tag, "_parity"}, 64'(parity_cnt),
          64'(v.par));
    check({tag, "_done_once"}, 64'(done_cnt), 64'd1);
    check({tag, "_rd_en"}, 64'(rden_cnt),
          64'(v.rdens));
    if (v.rdens > 0)
      check({tag, "_last_addr"}, 64'(last_addr),
            64'(v.laddr));
    check({tag, "_busy_end"}, 64'(busy), 64'd0);
    check({tag, "_sb_empty"}, 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    bit          ok;
    logic [31:0] x;
    int          d0;

    tbl[0] = '{3,   0, 0, 10,  32'hE0F0_0003, 1,   3,   8'd2};
    tbl[1] = '{3,   1, 0, 7,   32'hE0F0_0002, 1,   3,   8'd2};
    tbl[2] = '{0,   0, 0, 1,   32'hE0F0_0000, 0,   0,   8'd0};
    tbl[3] = '{3,   0, 1, 10,  32'hE0F0_0003, 1,   3,   8'd2};
    tbl[4] = '{8,   1, 1, 22,  32'hE0F0_0007, 1,   8,   8'd7};
    tbl[5] = '{300, 0, 0, 769, 32'hE0F0_0100, 129, 256, 8'd255};

    mem[0] = {4'h8, 32'hAAAA_0000, 40'h11_2233_4455};
    mem[1] = {4'h0, 32'h1234_5678, 40'h00_DEAD_BEEF};
    mem[2] = {4'h1, 32'h5555_AAAA, 40'h7F_CAFE_BABE};
    for (int i = 3; i < 256; i++) begin
      x      = 32'(i);
      mem[i] = {x[3:0], x * 32'h0101_0101,
                x[7:0], ~x};
    end

    reset     = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    filter_en = 1'b0;
    log_count = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctl",
          {out.valid, out.last, busy, done, rd_en},
          '0);
    check("rst_data", out.data, '0);
    check("rst_addr", rd_addr, '0);
    check("rst_par", parity_cnt, '0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++)
      apply_vec(tbl[i], $sformatf("vec%0d", i));

    // Abort while entry 2 presents W1.
    sb_q.delete();
    push_expected(3, 0);
    done_cnt = 0;
    pulse_start(3, 0);
    wait_word(32'h5555_AAAA, ok);
    check("abort_reach_w1", 64'(ok), 64'd1);
    ready_fix = 1'b0;
    abort     = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort_valid", 64'(out.valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_par_kept", parity_cnt, 64'd1);
    sb_q.delete();
    repeat (5) @(negedge clk);
    check("abort_no_done", 64'(done_cnt), 64'd0);
    ready_fix = 1'b1;
    apply_vec(tbl[0], "rescan");

    // Async reset in the middle of entry 1 W2.
    sb_q.delete();
    push_expected(3, 0);
    done_cnt = 0;
    pulse_start(3, 0);
    wait_word(32'hDEAD_BEEF, ok);
    check("rst_reach_w2", 64'(ok), 64'd1);
    d0 = done_cnt;
    #2;
    reset = 1'b1;
    #1;
    check("arst_ctl",
          {out.valid, out.last, busy, done, rd_en},
          '0);
    check("arst_data", out.data, '0);
    check("arst_addr", rd_addr, '0);
    check("arst_par", parity_cnt, '0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb_q.delete();
    repeat (5) @(negedge clk);
    check("arst_no_done", 64'(done_cnt), 64'(d0));
    check("arst_idle", 64'(busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
